// File: rtl/pyc_pkg.sv
// Shared definitions for the pyc credit-flow library.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pyc_pkg;

    // Width needed to hold every value from 0 up to and including n.
    function automatic int pyc_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pyc_credit_counter.sv
// Saturating up/down credit counter with zero/full decode and an overflow pulse.
// Latency: count updates one cycle after inc/dec; zero/full follow count, ovf_pulse is combinational.
// Backpressure: none; an inc at MAX without a dec is dropped and flagged on ovf_pulse.
module pyc_credit_counter
    import pyc_pkg::*;
#(
    parameter int MAX  = 2,
    parameter int INIT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inc,
    input  logic                      dec,
    output logic [pyc_cnt_w(MAX)-1:0] count,
    output logic                      zero,
    output logic                      full,
    output logic                      ovf_pulse
);

    localparam int W = pyc_cnt_w(MAX);
    localparam logic [W-1:0] MAX_C  = W'(MAX);
    localparam logic [W-1:0] INIT_C = W'(INIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         ovf;

    // Next count: simultaneous inc and dec cancel; saturate at both ends.
    always_comb begin
        count_d = count_q;
        ovf     = 1'b0;
        if (inc && !dec) begin
            if (count_q == MAX_C) begin
                ovf = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dec && !inc) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Count register; reset reloads the initial value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= INIT_C;
        end else begin
            count_q <= count_d;
        end
    end

    // The count must never exceed its ceiling.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= MAX_C)
            else $error("pyc_credit_counter: count %0d exceeds %0d", count_q, MAX);
        end
    end

    assign count     = count_q;
    assign zero      = (count_q == '0);
    assign full      = (count_q == MAX_C);
    assign ovf_pulse = ovf;

endmodule

// File: rtl/pyc_credit_tx.sv
// Credit-based transmitter: forwards a ready/valid stream onto a valid-only link into a remote FIFO.
// Latency: 1 cycle from accepted beat to tx_valid/tx_data.
// Backpressure: in_ready drops when credits reach zero; it is decoded from registered state only.
module pyc_credit_tx
    import pyc_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int CREDITS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          tx_valid,
    output logic [WIDTH-1:0]              tx_data,
    input  logic                          credit_in,
    output logic [pyc_cnt_w(CREDITS)-1:0] credits,
    output logic                          idle,
    output logic                          credit_err
);

    // A zero-depth remote buffer could never accept anything.
    if (CREDITS < 1) begin : g_bad_credits
        $fatal(1, "pyc_credit_tx: CREDITS must be >= 1");
    end

    logic             send;
    logic             cnt_zero;
    logic             cnt_full;
    logic             cnt_ovf;

    logic             tx_valid_q;
    logic             tx_valid_d;
    logic [WIDTH-1:0] tx_data_q;
    logic [WIDTH-1:0] tx_data_d;
    logic             credit_err_q;
    logic             credit_err_d;

    // Each send consumes a credit, each returned pulse restores one.
    pyc_credit_counter #(
        .MAX  (CREDITS),
        .INIT (CREDITS)
    ) u_credit_counter (
        .clk       (clk),
        .rst       (rst),
        .inc       (credit_in),
        .dec       (send),
        .count     (credits),
        .zero      (cnt_zero),
        .full      (cnt_full),
        .ovf_pulse (cnt_ovf)
    );

    assign in_ready = !cnt_zero;
    assign send     = in_valid && in_ready;

    // Output beat and sticky error next-state; data holds when nothing is sent.
    always_comb begin
        tx_valid_d   = send;
        tx_data_d    = tx_data_q;
        credit_err_d = credit_err_q | cnt_ovf;
        if (send) begin
            tx_data_d = in_data;
        end
    end

    // Output stage and error flag; reset drops any beat in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            credit_err_q <= 1'b0;
        end else begin
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign credit_err = credit_err_q;
    assign idle       = cnt_full && !tx_valid_q;

endmodule
